regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Synthesisable multi-port integer register file for the RISC-V core; replaces the simulation-only DPI register hook.
- Provides parametrised read and write port counts, optional same-cycle write-to-read bypass and a hardwired-zero x0.
- Clears all entries after reset with a sequential init sweep.
- Emits a registered per-port commit trace that the difftest harness consumes instead of DPI calls.

Parameters:
- REG_NUM_WIDTH, 5, register address width; depth = 2^REG_NUM_WIDTH.
- REG_WIDTH, 32, data width of each register.
- NUM_RD_PORTS, 2, number of read ports (1..4).
- NUM_WR_PORTS, 2, number of write ports (1..2).
- BYPASS, 1, 1 = a read returns same-cycle write data for a matching address.
- ZERO_REG, 1, 1 = address 0 always reads 0; writes to it are discarded.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  NUM_WR_PORTS  per-port write enable.
- wr_addr  in  NUM_WR_PORTS*REG_NUM_WIDTH  packed write addresses; port i at slice i.
- wr_data  in  NUM_WR_PORTS*REG_WIDTH  packed write data.
- rd_en  in  NUM_RD_PORTS  per-port read enable.
- rd_addr  in  NUM_RD_PORTS*REG_NUM_WIDTH  packed read addresses.
- rd_data  out  NUM_RD_PORTS*REG_WIDTH  packed read data, combinational.
- ready  out  1  high once the init sweep is done; writes are accepted only while high.
- trace_valid  out  NUM_WR_PORTS  registered: port i committed a write on the previous edge.
- trace_addr  out  NUM_WR_PORTS*REG_NUM_WIDTH  registered committed address.
- trace_data  out  NUM_WR_PORTS*REG_WIDTH  registered committed data.

Behaviour:
- Reset: a clock edge with reset=1 sets:
  - state=INIT, sweep counter=0, ready=0;
  - trace_valid=0, trace_addr=0, trace_data=0.
- Reset asserted mid-sweep or mid-run restarts the sweep from 0. Array contents are otherwise undefined until swept.
- FSM INIT:
  - Each edge writes 0 to entry[counter] and increments the counter.
  - After writing entry 2^REG_NUM_WIDTH-1, moves to RUN.
  - The sweep takes exactly 2^REG_NUM_WIDTH edges after reset deasserts; ready rises with the RUN state.
  - During INIT: wr_en is ignored (no commit, no trace) and rd_data = 0 for all ports.
- FSM RUN:
  - Stays in RUN until reset. ready=1.
- Write commit (RUN only): port i commits on an edge when all of the following hold:
  - wr_en[i]=1;
  - NOT (ZERO_REG=1 and wr_addr[i]=0);
  - port i does not lose a same-address conflict.
- Write conflict: if both ports are enabled to the same address, port 1 wins. Port 0 does not commit and its trace_valid stays 0.
- Trace:
  - trace_valid[i] = 1 for exactly the cycle after each commit of port i.
  - trace_addr/trace_data hold the committed values and keep them while trace_valid=0.
- Read, combinational, zero-latency:
  - rd_en[j]=0 -> rd_data[j]=0.
  - ZERO_REG=1 and rd_addr[j]=0 -> 0.
  - BYPASS=1 and some port k would commit this edge to rd_addr[j] -> wr_data of the winning port.
  - Otherwise -> entry[rd_addr[j]].
  - BYPASS=0 returns the pre-edge array value; new data is visible the cycle after the write.
- Any number of read ports may address the same entry simultaneously; all return identical data.
- No arithmetic; all widths are exact; no truncation or extension.

Test Plan:
- Init sweep: pulse reset 1 cycle with defaults -> ready=0 for 32 edges then 1; every rd_addr 0..31 reads 0x00000000; wr_en pulses during INIT produce no trace_valid.
- Basic write/read, BYPASS=0: write port0 addr 5 data 0xDEADBEEF -> rd_data on addr 5 reads old 0 that cycle and 0xDEADBEEF next cycle; trace_valid=01, trace_addr[0]=5, trace_data[0]=0xDEADBEEF for one cycle.
- Bypass, BYPASS=1: same-cycle write port1 addr 7 data 0x12345678 and rd_addr[0]=7 -> rd_data[0]=0x12345678 combinationally in that cycle.
- x0: write addr 0 data 0xFFFFFFFF -> rd addr 0 returns 0; trace_valid stays 0; with ZERO_REG=0 it reads 0xFFFFFFFF.
- Conflict: port0 and port1 both write addr 9 with 0xAAAA0000 and 0x5555FFFF -> addr 9 reads 0x5555FFFF; trace_valid=10.
- Reset mid-run: after writing addr 3 = 0x1, assert reset -> ready drops, trace clears, sweep repeats 32 cycles, addr 3 reads 0 after ready.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with a post-reset zeroing sweep, optional
// write-to-read bypass, hardwired x0 and a registered per-port commit trace.
module regfile_mp #(
    parameter int REG_NUM_WIDTH = 5,
    parameter int REG_WIDTH     = 32,
    parameter int NUM_RD_PORTS  = 2,
    parameter int NUM_WR_PORTS  = 2,
    parameter int BYPASS        = 1,
    parameter int ZERO_REG      = 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_WR_PORTS-1:0]               wr_en,
    input  logic [NUM_WR_PORTS*REG_NUM_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR_PORTS*REG_WIDTH-1:0]     wr_data,
    input  logic [NUM_RD_PORTS-1:0]               rd_en,
    input  logic [NUM_RD_PORTS*REG_NUM_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*REG_WIDTH-1:0]     rd_data,
    output logic                                  ready,
    output logic [NUM_WR_PORTS-1:0]               trace_valid,
    output logic [NUM_WR_PORTS*REG_NUM_WIDTH-1:0] trace_addr,
    output logic [NUM_WR_PORTS*REG_WIDTH-1:0]     trace_data
);

    localparam int DEPTH = 1 << REG_NUM_WIDTH;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]                              state_r;
    logic [REG_NUM_WIDTH-1:0]                sweep_cnt_r;
    logic                                    ready_r;
    logic [REG_WIDTH-1:0]                    mem_r [DEPTH];
    logic [NUM_WR_PORTS-1:0]                 commit_s;
    logic [REG_WIDTH-1:0]                    rd_val_s [NUM_RD_PORTS];
    logic [NUM_WR_PORTS-1:0]                 trace_valid_r;
    logic [NUM_WR_PORTS*REG_NUM_WIDTH-1:0]   trace_addr_r;
    logic [NUM_WR_PORTS*REG_WIDTH-1:0]       trace_data_r;

    function automatic logic is_zero_addr(input logic [REG_NUM_WIDTH-1:0] addr);
        return (ZERO_REG != 0) && (addr == {REG_NUM_WIDTH{1'b0}});
    endfunction

    // Decide which write ports commit this edge; a higher-numbered port wins an address clash.
    always_comb begin
        commit_s = {NUM_WR_PORTS{1'b0}};
        for (int i = 0; i < NUM_WR_PORTS; i++) begin
            commit_s[i] = wr_en[i] && (state_r == ST_RUN)
                          && !is_zero_addr(wr_addr[i*REG_NUM_WIDTH +: REG_NUM_WIDTH]);
            for (int k = i + 1; k < NUM_WR_PORTS; k++) begin
                commit_s[i] = commit_s[i] & ~(wr_en[k] &&
                    (wr_addr[k*REG_NUM_WIDTH +: REG_NUM_WIDTH] ==
                     wr_addr[i*REG_NUM_WIDTH +: REG_NUM_WIDTH]));
            end
        end
    end

    // Combinational read path with optional forwarding of this edge's committed data.
    always_comb begin
        for (int j = 0; j < NUM_RD_PORTS; j++) begin
            rd_val_s[j] = {REG_WIDTH{1'b0}};
            if ((state_r == ST_RUN) && rd_en[j] &&
                !is_zero_addr(rd_addr[j*REG_NUM_WIDTH +: REG_NUM_WIDTH])) begin
                rd_val_s[j] = mem_r[rd_addr[j*REG_NUM_WIDTH +: REG_NUM_WIDTH]];
                for (int k = 0; k < NUM_WR_PORTS; k++) begin
                    rd_val_s[j] = ((BYPASS != 0) && commit_s[k] &&
                                   (wr_addr[k*REG_NUM_WIDTH +: REG_NUM_WIDTH] ==
                                    rd_addr[j*REG_NUM_WIDTH +: REG_NUM_WIDTH]))
                                  ? wr_data[k*REG_WIDTH +: REG_WIDTH] : rd_val_s[j];
                end
            end else begin
                rd_val_s[j] = {REG_WIDTH{1'b0}};
            end
        end
    end

    // Pack per-port read values onto the flat output bus.
    always_comb begin
        rd_data = {(NUM_RD_PORTS*REG_WIDTH){1'b0}};
        for (int j = 0; j < NUM_RD_PORTS; j++) begin
            rd_data[j*REG_WIDTH +: REG_WIDTH] = rd_val_s[j];
        end
    end

    // Sequencer: zeroing sweep after reset, then RUN until the next reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_INIT;
            sweep_cnt_r <= {REG_NUM_WIDTH{1'b0}};
            ready_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    sweep_cnt_r <= sweep_cnt_r + REG_NUM_WIDTH'(1);
                    if (sweep_cnt_r == {REG_NUM_WIDTH{1'b1}}) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_INIT;
                        ready_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    sweep_cnt_r <= {REG_NUM_WIDTH{1'b0}};
                    ready_r     <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: zero one entry per edge while sweeping, otherwise apply commits.
    always_ff @(posedge clock) begin
        if (!reset && (state_r == ST_INIT)) begin
            mem_r[sweep_cnt_r] <= {REG_WIDTH{1'b0}};
        end else if (!reset) begin
            for (int i = 0; i < NUM_WR_PORTS; i++) begin
                if (commit_s[i]) begin
                    mem_r[wr_addr[i*REG_NUM_WIDTH +: REG_NUM_WIDTH]] <= wr_data[i*REG_WIDTH +: REG_WIDTH];
                end
            end
        end
    end

    // Commit trace: one-cycle valid pulse, address/data held until the next commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            trace_valid_r <= {NUM_WR_PORTS{1'b0}};
            trace_addr_r  <= {(NUM_WR_PORTS*REG_NUM_WIDTH){1'b0}};
            trace_data_r  <= {(NUM_WR_PORTS*REG_WIDTH){1'b0}};
        end else begin
            for (int i = 0; i < NUM_WR_PORTS; i++) begin
                trace_valid_r[i] <= commit_s[i];
                if (commit_s[i]) begin
                    trace_addr_r[i*REG_NUM_WIDTH +: REG_NUM_WIDTH] <= wr_addr[i*REG_NUM_WIDTH +: REG_NUM_WIDTH];
                    trace_data_r[i*REG_WIDTH +: REG_WIDTH]         <= wr_data[i*REG_WIDTH +: REG_WIDTH];
                end
            end
        end
    end

    assign ready       = ready_r;
    assign trace_valid = trace_valid_r;
    assign trace_addr  = trace_addr_r;
    assign trace_data  = trace_data_r;

endmodule
